// File: rtl/tile_ram_arbiter.sv
// rtl/tile_ram_arbiter.sv - tile-map RAM arbiter: pixel reads > game reads > buffered game writes
// Define TILE_ARB_STALL_STATS_EN to add the wr_stall_cnt blocked-write cycle counter.
module tile_ram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_vga,
  input  logic              reset,
  input  logic              pix_rd_en,
  input  logic [ADDR_W-1:0] pix_rd_addr,
  output logic              pix_rd_valid,
  output logic [DATA_W-1:0] pix_rd_data,
  input  logic              gl_wr_valid,
  output logic              gl_wr_ready,
  input  logic [ADDR_W-1:0] gl_wr_addr,
  input  logic [DATA_W-1:0] gl_wr_data,
  input  logic              gl_rd_req,
  input  logic [ADDR_W-1:0] gl_rd_addr,
  output logic              gl_rd_ack,
  output logic [DATA_W-1:0] gl_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
`ifdef TILE_ARB_STALL_STATS_EN
  output logic [15:0]       wr_stall_cnt,
`endif
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {TAG_NONE, TAG_PIX, TAG_GL} tag_t;
  typedef enum logic [2:0] {RD_IDLE, RD_WAIT_DRAIN, RD_ISSUE, RD_INFLIGHT, RD_DONE} rd_state_t;

  rd_state_t rd_state, rd_next;
  logic      infl_cnt;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic                     push, pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;

  tag_t grant_tag, tag_q0, tag_q1;

  assign gl_wr_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push        = gl_wr_valid && gl_wr_ready;
  assign {head_addr, head_data} = fifo_mem[rd_ptr];

  // Grant priority; ISSUE also blocks pops so later writes cannot overtake the read.
  always_comb begin
    grant_tag = TAG_NONE;
    pop       = 1'b0;
    if (pix_rd_en)
      grant_tag = TAG_PIX;
    else if (rd_state == RD_ISSUE)
      grant_tag = TAG_GL;
    else if (fifo_level != '0)
      pop = 1'b1;
  end

  always_ff @(posedge clk_vga) begin
    if (push)
      fifo_mem[wr_ptr] <= {gl_wr_addr, gl_wr_data};
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // RAM port: address holds its last value on idle cycles.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= pop;
      if (grant_tag == TAG_PIX)
        ram_addr <= pix_rd_addr;
      else if (grant_tag == TAG_GL)
        ram_addr <= gl_rd_addr;
      else if (pop) begin
        ram_addr  <= head_addr;
        ram_wdata <= head_data;
      end
    end
  end

  // tag_q0 travels with ram_addr, tag_q1 with ram_rdata.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      tag_q0       <= TAG_NONE;
      tag_q1       <= TAG_NONE;
      pix_rd_valid <= 1'b0;
      pix_rd_data  <= '0;
      gl_rd_data   <= '0;
    end else begin
      tag_q0       <= grant_tag;
      tag_q1       <= tag_q0;
      pix_rd_valid <= (tag_q1 == TAG_PIX);
      pix_rd_data  <= (tag_q1 == TAG_PIX) ? ram_rdata : '0;
      gl_rd_data   <= (tag_q1 == TAG_GL) ? ram_rdata : '0;
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      infl_cnt <= 1'b0;
    end else begin
      rd_state <= rd_next;
      infl_cnt <= (rd_state == RD_INFLIGHT) && !infl_cnt;
    end
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:       if (gl_rd_req) rd_next = RD_WAIT_DRAIN;
      RD_WAIT_DRAIN: if (fifo_level == '0) rd_next = RD_ISSUE;
      RD_ISSUE:      if (!pix_rd_en) rd_next = RD_INFLIGHT;
      RD_INFLIGHT:   if (infl_cnt) rd_next = RD_DONE;
      RD_DONE:       rd_next = RD_IDLE;
      default:       rd_next = RD_IDLE;
    endcase
  end

  always_comb begin
    gl_rd_ack = (rd_state == RD_DONE);
  end

`ifdef TILE_ARB_STALL_STATS_EN
  always_ff @(posedge clk_vga) begin
    if (reset)
      wr_stall_cnt <= '0;
    else if (fifo_level != '0 && pix_rd_en && wr_stall_cnt != 16'hFFFF)
      wr_stall_cnt <= wr_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// tb/tb_tile_ram_arbiter.sv - scoreboard bench for tile_ram_arbiter
module tb_tile_ram_arbiter;

  logic        clk_vga = 1'b0;
  logic        reset = 1'b1;
  logic        pix_rd_en = 1'b0;
  logic [9:0]  pix_rd_addr = '0;
  logic        pix_rd_valid;
  logic [15:0] pix_rd_data;
  logic        gl_wr_valid = 1'b0;
  logic        gl_wr_ready;
  logic [9:0]  gl_wr_addr = '0;
  logic [15:0] gl_wr_data = '0;
  logic        gl_rd_req = 1'b0;
  logic [9:0]  gl_rd_addr = '0;
  logic        gl_rd_ack;
  logic [15:0] gl_rd_data;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [2:0]  fifo_level;
`ifdef TILE_ARB_STALL_STATS_EN
  logic [15:0] wr_stall_cnt;
`endif

  tile_ram_arbiter #(.ADDR_W(10), .DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk_vga(clk_vga), .reset(reset),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr),
    .pix_rd_valid(pix_rd_valid), .pix_rd_data(pix_rd_data),
    .gl_wr_valid(gl_wr_valid), .gl_wr_ready(gl_wr_ready),
    .gl_wr_addr(gl_wr_addr), .gl_wr_data(gl_wr_data),
    .gl_rd_req(gl_rd_req), .gl_rd_addr(gl_rd_addr),
    .gl_rd_ack(gl_rd_ack), .gl_rd_data(gl_rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
`ifdef TILE_ARB_STALL_STATS_EN
    .wr_stall_cnt(wr_stall_cnt),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk_vga = ~clk_vga;

  int cyc = 0;
  always @(posedge clk_vga) cyc <= cyc + 1;

  // Single-port synchronous-read RAM, preloaded with word[a] = a + 100.
  logic [15:0] mem [1024];
  bit mem_init = 1'b0;
  always @(posedge clk_vga) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'(i + 100);
      mem_init <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef struct { int cyc; logic [15:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [9:0] addr; logic [15:0] data; } wr_exp_t;

  rd_exp_t exp_pix[$];
  rd_exp_t exp_gl[$];
  wr_exp_t exp_wr[$];

  int total = 0;
  int bad = 0;
  int ack_count = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_pix(input logic [9:0] a);
    rd_exp_t e;
    pix_rd_en   = 1'b1;
    pix_rd_addr = a;
    e.cyc  = cyc + 3;
    e.data = 16'(a) + 16'd100;
    exp_pix.push_back(e);
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [15:0] d, input int c);
    wr_exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_gl(input logic [15:0] d, input int c);
    rd_exp_t e;
    e.cyc = c; e.data = d;
    exp_gl.push_back(e);
  endtask

  rd_exp_t pe, ge;
  wr_exp_t we_e;

  // Monitor: pops the scoreboards whenever the DUT presents a read result or a RAM write.
  always @(negedge clk_vga) begin
    if (mon_en) begin
      if (pix_rd_valid) begin
        if (exp_pix.size() == 0) check("pix_unexpected", 1, 0);
        else begin
          pe = exp_pix.pop_front();
          check("pix_data", pix_rd_data, pe.data);
          check("pix_cycle", cyc, pe.cyc);
        end
      end else begin
        check("pix_idle_zero", pix_rd_data, 0);
      end
      if (gl_rd_ack) begin
        ack_count++;
        if (exp_gl.size() == 0) check("gl_unexpected_ack", 1, 0);
        else begin
          ge = exp_gl.pop_front();
          check("gl_data", gl_rd_data, ge.data);
          check("gl_cycle", cyc, ge.cyc);
        end
      end
      if (ram_we) begin
        if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          we_e = exp_wr.pop_front();
          check("wr_addr", ram_addr, we_e.addr);
          check("wr_data", ram_wdata, we_e.data);
          if (we_e.cyc >= 0) check("wr_cycle", cyc, we_e.cyc);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int c0, p_edge, acc_edge, a0;
  bit got;

  initial begin
    repeat (3) @(negedge clk_vga);
    mon_en = 1'b1;
    check("rst_wr_ready", gl_wr_ready, 1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_pix_valid", pix_rd_valid, 0);
    check("rst_gl_ack", gl_rd_ack, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_vga);
    check("idle_wr_ready", gl_wr_ready, 1);
    check("idle_fifo_level", fifo_level, 0);
    check("idle_ram_we", ram_we, 0);

    // Pixel burst 0..7
    for (int a = 0; a < 8; a++) begin
      drive_pix(10'(a));
      @(negedge clk_vga);
    end
    pix_rd_en = 1'b0;
    repeat (4) @(negedge clk_vga);

    // Four writes fill the FIFO while the pixel port is busy; a fifth is held
    for (int k = 0; k < 4; k++) begin
      drive_pix(10'(20 + k));
      gl_wr_valid = 1'b1;
      gl_wr_addr  = 10'(5 + k);
      gl_wr_data  = 16'h00A0 + 16'(k);
      push_wr(10'(5 + k), 16'h00A0 + 16'(k), -1);
      @(negedge clk_vga);
    end
    drive_pix(10'd24);
    gl_wr_addr = 10'd9;
    gl_wr_data = 16'h00A4;
    push_wr(10'd9, 16'h00A4, -1);
    check("full_level", fifo_level, 4);
    check("full_ready", gl_wr_ready, 0);
    @(negedge clk_vga);
    drive_pix(10'd25);
    check("held_level", fifo_level, 4);
    check("held_ready", gl_wr_ready, 0);
    @(negedge clk_vga);
    pix_rd_en = 1'b0;
    p_edge = cyc + 1;
    check("wr_queue_size", exp_wr.size(), 5);
    if (exp_wr.size() >= 5)
      for (int k = 0; k < 5; k++) exp_wr[k].cyc = p_edge + k;
    acc_edge = -1;
    for (int t = 0; t < 20 && acc_edge < 0; t++) begin
      @(negedge clk_vga);
      if (gl_wr_ready) acc_edge = cyc + 1;
    end
    check("wr5_accept_edge", acc_edge, p_edge + 1);
    @(negedge clk_vga);
    gl_wr_valid = 1'b0;
    repeat (8) @(negedge clk_vga);
    check("drained_level", fifo_level, 0);

    // Write to addr 3, then a game read of addr 3 behind it while pixels run
    c0 = cyc;
    drive_pix(10'd30);
    gl_wr_valid = 1'b1;
    gl_wr_addr  = 10'd3;
    gl_wr_data  = 16'hBEEF;
    push_wr(10'd3, 16'hBEEF, c0 + 7);
    push_gl(16'hBEEF, c0 + 11);
    @(negedge clk_vga);
    gl_wr_valid = 1'b0;
    gl_rd_req   = 1'b1;
    gl_rd_addr  = 10'd3;
    for (int k = 0; k < 5; k++) begin
      drive_pix(10'(31 + k));
      @(negedge clk_vga);
    end
    pix_rd_en = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk_vga);
      if (gl_rd_ack) got = 1'b1;
    end
    check("beef_ack_seen", got, 1);
    gl_rd_req = 1'b0;
    repeat (4) @(negedge clk_vga);

    // Game read parked in ISSUE while the pixel port toggles 1,0
    c0 = cyc;
    gl_rd_req  = 1'b1;
    gl_rd_addr = 10'd6;
    push_gl(16'h00A1, c0 + 6);
    drive_pix(10'd40);
    @(negedge clk_vga);
    drive_pix(10'd41);
    @(negedge clk_vga);
    drive_pix(10'd42);
    @(negedge clk_vga);
    pix_rd_en = 1'b0;
    @(negedge clk_vga);
    drive_pix(10'd43);
    @(negedge clk_vga);
    drive_pix(10'd44);
    @(negedge clk_vga);
    pix_rd_en = 1'b0;
    gl_rd_req = 1'b0;
    repeat (4) @(negedge clk_vga);

    // Reset while a game read (and a pixel read) is in flight: both dropped
    a0 = ack_count;
    gl_rd_req  = 1'b1;
    gl_rd_addr = 10'd6;
    repeat (3) @(negedge clk_vga);
    gl_rd_req   = 1'b0;
    pix_rd_en   = 1'b1;
    pix_rd_addr = 10'd50;
    @(negedge clk_vga);
    pix_rd_en = 1'b0;
    reset     = 1'b1;
    @(negedge clk_vga);
    reset = 1'b0;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ready", gl_wr_ready, 1);
    repeat (6) @(negedge clk_vga);
    check("no_ack_after_reset", ack_count, a0);

    // FSM back in IDLE: a fresh read completes with the minimum latency
    gl_rd_req  = 1'b1;
    gl_rd_addr = 10'd6;
    push_gl(16'h00A1, cyc + 5);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk_vga);
      if (gl_rd_ack) got = 1'b1;
    end
    check("post_rst_ack_seen", got, 1);
    gl_rd_req = 1'b0;
    repeat (4) @(negedge clk_vga);

`ifdef TILE_ARB_STALL_STATS_EN
    check("stall_cnt_start", wr_stall_cnt, 0);
    drive_pix(10'd200);
    gl_wr_valid = 1'b1;
    gl_wr_addr  = 10'd2;
    gl_wr_data  = 16'h0222;
    push_wr(10'd2, 16'h0222, -1);
    @(negedge clk_vga);
    gl_wr_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive_pix(10'(201 + k));
      @(negedge clk_vga);
    end
    pix_rd_en = 1'b0;
    @(negedge clk_vga);
    check("stall_cnt_10", wr_stall_cnt, 10);
    repeat (4) @(negedge clk_vga);
    drive_pix(10'd300);
    gl_wr_valid = 1'b1;
    gl_wr_addr  = 10'd1;
    gl_wr_data  = 16'h0111;
    push_wr(10'd1, 16'h0111, -1);
    @(negedge clk_vga);
    gl_wr_valid = 1'b0;
    for (int k = 0; k < 70000; k++) begin
      drive_pix(10'(300 + (k % 256)));
      @(negedge clk_vga);
    end
    pix_rd_en = 1'b0;
    @(negedge clk_vga);
    check("stall_cnt_sat", wr_stall_cnt, 16'hFFFF);
    repeat (4) @(negedge clk_vga);
`endif

    repeat (6) @(negedge clk_vga);
    check("pix_queue_empty", exp_pix.size(), 0);
    check("gl_queue_empty", exp_gl.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_ram_arbiter.md
Name: tile_ram_arbiter

Overview:
- Shares one single-port, synchronous-read tile-map RAM among three requesters:
  - the pixel pipeline's per-pixel read port, which feeds gen_red/green/blue selection;
  - a game-logic write port;
  - a game-logic read port.
- Pixel reads have absolute priority so scan-out never stalls.
- Game-logic writes are buffered in a small FIFO and drained only in cycles the pixel port leaves idle, normally blanking.
- Game-logic reads are ordered behind all queued writes.

Parameters:
- ADDR_W, 10, tile RAM address width.
- DATA_W, 16, tile RAM data width.
- FIFO_DEPTH, 4, write FIFO entries; power of two, at least 2.

Ports:
- clk_vga  in  1  pixel clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- pix_rd_en  in  1  pixel pipeline requests a read this cycle.
- pix_rd_addr  in  ADDR_W  pixel read address.
- pix_rd_valid  out  1  pixel read data valid.
- pix_rd_data  out  DATA_W  pixel read data.
- gl_wr_valid  in  1  game-logic write request.
- gl_wr_ready  out  1  FIFO can accept a write.
- gl_wr_addr  in  ADDR_W  write address.
- gl_wr_data  in  DATA_W  write data.
- gl_rd_req  in  1  game-logic read request; held high until ack.
- gl_rd_addr  in  ADDR_W  game read address; stable while req is high.
- gl_rd_ack  out  1  one-cycle pulse, gl_rd_data valid.
- gl_rd_data  out  DATA_W  game read data.
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, one cycle after ram_addr.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: all outputs 0, except gl_wr_ready = 1. FIFO is emptied, the read FSM goes to IDLE, and the pipeline tags are cleared. A request in flight when reset is asserted is dropped; no ack is issued.
- Write push: on any edge where gl_wr_valid && gl_wr_ready, {addr, data} is pushed. gl_wr_ready = (fifo_level != FIFO_DEPTH), computed combinationally from the registered level.
- Per-cycle grant, evaluated on inputs at edge T and registered onto the ram_* outputs for cycle T+1, in priority order:
  1. pix_rd_en: issue a pixel read.
  2. Else if the read FSM is in ISSUE: issue a game read.
  3. Else if the FIFO is non-empty: pop the head and write it (ram_we = 1).
  4. Else: idle, ram_we = 0, ram_addr holds its previous value.
- Simultaneous push and pop in one cycle: level is unchanged. A pop and push on a full FIFO is allowed only if gl_wr_ready was already high; no same-cycle bypass.
- Read latency is a fixed 2 cycles for both read ports:
  - Pixel read: pix_rd_en at edge T gives pix_rd_valid high in cycle T+2 with pix_rd_data = ram_rdata.
  - pix_rd_data is 0 whenever pix_rd_valid = 0.
  - A back-to-back pix_rd_en stream gives a continuous valid stream, one word per cycle.
  - Game read: same timing; gl_rd_ack pulses in the cycle its data returns.
  - Each read is tagged in a 2-stage shift register (pix / gl / none) to route data.
- Game-read FSM:
  - IDLE -> WAIT_DRAIN when gl_rd_req = 1.
  - WAIT_DRAIN -> ISSUE when fifo_level == 0. The game read sees every write accepted before it.
  - ISSUE -> INFLIGHT when the read is granted, i.e. pix_rd_en = 0 that cycle. Otherwise stay in ISSUE.
  - INFLIGHT -> DONE after 2 cycles. gl_rd_ack = 1 in the DONE cycle.
  - DONE -> IDLE. The requester must drop req by the cycle after ack; req still high in IDLE starts a new read.
  - While in ISSUE, pops are blocked, so FIFO writes accepted meanwhile cannot overtake the read.
- No starvation guard: a continuous pix_rd_en stream stalls writes and game reads indefinitely. Correct by design, since blanking recurs every line.

Optional Feature:
- Macro TILE_ARB_STALL_STATS_EN.
- When defined:
  - Adds output port wr_stall_cnt, 16 bits.
  - Counts cycles where fifo_level != 0 and pix_rd_en = 1, i.e. writes pending but blocked.
  - Saturates at 16'hFFFF; cleared by reset.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle: gl_wr_ready = 1, fifo_level = 0, ram_we = 0, all valids 0.
- pix_rd_en held 8 cycles, addr 0..7, with RAM word[a] = a+100: pix_rd_valid high cycles T+2..T+9 with data 100..107, never ram_we.
- 4 writes (addr 5..8, data A0..A3) pushed while pix_rd_en = 1 continuously:
  - fifo_level reaches 4 and gl_wr_ready drops; a 5th write is held.
  - When pix_rd_en falls, ram_we pulses 4 consecutive cycles in order.
  - The 5th write is accepted the cycle after the first pop.
- Push write addr 3 = BEEF, then immediately gl_rd_req addr 3 with pix_rd_en = 1 for 5 more cycles: the write commits first; gl_rd_ack comes 2 cycles after the grant with gl_rd_data = BEEF.
- gl_rd in ISSUE while pix_rd_en toggles 1,0: the grant occurs in the 0 cycle; pixel data on preceding cycles is unaffected. Reset asserted in INFLIGHT gives no ack and FSM IDLE.
- With TILE_ARB_STALL_STATS_EN: 10 blocked cycles give wr_stall_cnt = 10; a 70000-cycle block saturates at 65535.
